// File: rtl/sdram_rom_loader.sv
// sdram_rom_loader: packs ioctl bytes into words and feeds the SDRAM ROM port.
// Optional running sum of issued words: SDRAM_ROM_LOADER_CHECKSUM_EN.
module sdram_rom_loader #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 24
) (
    input  logic              clk,
    input  logic              init_n,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [ADDR_W-1:0] ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    output logic [ADDR_W-2:0] rom_addr,
    output logic [15:0]       rom_din,
    output logic              rom_we,
    output logic              rom_req,
    input  logic              rom_req_ack,
    output logic              done,
    output logic              overflow,
    output logic [15:0]       checksum
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] HIGH = CW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        SYNC,
        IDLE,
        WAIT
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic              r_dl_q;
    logic              w_dl_rise;
    logic              w_dl_fall;
    logic              w_wr;
    logic              r_pend_v;
    logic [7:0]        r_pend_b;
    logic [ADDR_W-2:0] r_pend_a;
    logic [ADDR_W-2:0] w_wr_a;
    logic              w_match;
    logic [15:0]       r_mem_d [FIFO_DEPTH];
    logic [ADDR_W-2:0] r_mem_a [FIFO_DEPTH];
    logic [PW-1:0]     r_wp;
    logic [PW-1:0]     r_rp;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cnt_nxt;
    logic              w_push;
    logic              w_push_ok;
    logic [15:0]       w_push_d;
    logic [ADDR_W-2:0] w_push_a;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              r_armed;
    logic              w_fin;

    assign w_dl_rise = ioctl_download & ~r_dl_q;
    assign w_dl_fall = ~ioctl_download & r_dl_q;
    assign w_wr      = ioctl_wr & ioctl_download;
    assign w_wr_a    = ioctl_addr[ADDR_W-1:1];
    assign w_match   = r_pend_v && (r_pend_a == w_wr_a);
    assign w_full    = (r_cnt == FULL);
    assign w_empty   = (r_cnt == '0);
    assign w_push_ok = w_push & ~w_full;
    assign w_fin     = r_armed & ~ioctl_download & ~r_pend_v
                     & w_empty & (r_state == IDLE);

    // An even byte arriving over a pending one flushes the old low byte.
    always_comb begin
        w_push   = 1'b0;
        w_push_d = '0;
        w_push_a = '0;
        if (w_wr) begin
            if (!ioctl_addr[0]) begin
                if (r_pend_v) begin
                    w_push   = 1'b1;
                    w_push_d = {8'h00, r_pend_b};
                    w_push_a = r_pend_a;
                end
            end else begin
                w_push   = 1'b1;
                w_push_a = w_wr_a;
                w_push_d = w_match ? {ioctl_dout, r_pend_b}
                                   : {ioctl_dout, 8'h00};
            end
        end else if (w_dl_fall && r_pend_v) begin
            w_push   = 1'b1;
            w_push_d = {8'h00, r_pend_b};
            w_push_a = r_pend_a;
        end
    end

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_push_ok && !w_pop) begin
            w_cnt_nxt = r_cnt + CW'(1);
        end else if (!w_push_ok && w_pop) begin
            w_cnt_nxt = r_cnt - CW'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        unique case (r_state)
            SYNC: w_state_nxt = IDLE;
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (rom_req == rom_req_ack) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = SYNC;
        endcase
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            r_state <= SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem_d[r_wp] <= w_push_d;
            r_mem_a[r_wp] <= w_push_a;
        end
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            r_dl_q     <= 1'b0;
            r_pend_v   <= 1'b0;
            r_pend_b   <= '0;
            r_pend_a   <= '0;
            r_wp       <= '0;
            r_rp       <= '0;
            r_cnt      <= '0;
            ioctl_wait <= 1'b0;
            overflow   <= 1'b0;
            r_armed    <= 1'b0;
        end else begin
            r_dl_q     <= ioctl_download;
            r_cnt      <= w_cnt_nxt;
            ioctl_wait <= (w_cnt_nxt >= HIGH);
            if (w_push_ok) begin
                r_wp <= r_wp + PW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + PW'(1);
            end
            if (w_push && w_full) begin
                overflow <= 1'b1;
            end
            if (w_wr) begin
                if (!ioctl_addr[0]) begin
                    r_pend_v <= 1'b1;
                    r_pend_b <= ioctl_dout;
                    r_pend_a <= w_wr_a;
                end else if (w_match) begin
                    r_pend_v <= 1'b0;
                end
            end else if (w_dl_fall) begin
                r_pend_v <= 1'b0;
            end
            if (w_dl_rise) begin
                r_armed <= 1'b0;
            end else if (w_dl_fall) begin
                r_armed <= 1'b1;
            end else if (w_fin) begin
                r_armed <= 1'b0;
            end
        end
    end

    // SYNC adopts the controller's ack parity so a stale ack is not a request.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            rom_addr <= '0;
            rom_din  <= '0;
            rom_we   <= 1'b0;
            rom_req  <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= w_fin;
            if (r_state == SYNC) begin
                rom_req <= rom_req_ack;
            end
            if (w_pop) begin
                rom_addr <= r_mem_a[r_rp];
                rom_din  <= r_mem_d[r_rp];
                rom_we   <= 1'b1;
                rom_req  <= ~rom_req;
            end else if (w_fin) begin
                rom_we <= 1'b0;
            end
        end
    end

`ifdef SDRAM_ROM_LOADER_CHECKSUM_EN
    logic [15:0] r_csum;

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            r_csum <= '0;
        end else if (w_dl_rise) begin
            r_csum <= w_pop ? r_mem_d[r_rp] : 16'h0000;
        end else if (w_pop) begin
            r_csum <= r_csum + r_mem_d[r_rp];
        end
    end

    assign checksum = r_csum;
`else
    assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_sdram_rom_loader.sv
// tb_sdram_rom_loader: vector table, corner sequences and randomized
// downloads checked against a word-level model of the byte packing rules.
module tb_sdram_rom_loader;
    typedef struct {
        logic [22:0] a;
        logic [15:0] d;
    } word_t;

    typedef struct {
        int          n;
        logic [23:0] a [4];
        logic [7:0]  d [4];
        int          nw;
        logic [22:0] ea [3];
        logic [15:0] ed [3];
    } vec_t;

    logic        clk = 1'b0;
    logic        init_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [23:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        rom_req_ack = 1'b0;
    logic        ioctl_wait;
    logic [22:0] rom_addr;
    logic [15:0] rom_din;
    logic        rom_we;
    logic        rom_req;
    logic        done;
    logic        overflow;
    logic [15:0] checksum;

    int    checks = 0;
    int    errors = 0;
    int    done_cnt = 0;
    bit    ack_en = 1'b0;
    int    ack_dly = 0;
    int    ack_wait = 0;
    logic  prev_req = 1'b0;
    word_t iss_q [$];
    word_t exp_q [$];
    logic [23:0] ba [$];
    logic [7:0]  bd [$];

    sdram_rom_loader dut (
        .clk            (clk),
        .init_n         (init_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .rom_addr       (rom_addr),
        .rom_din        (rom_din),
        .rom_we         (rom_we),
        .rom_req        (rom_req),
        .rom_req_ack    (rom_req_ack),
        .done           (done),
        .overflow       (overflow),
        .checksum       (checksum)
    );

    always #5 clk = ~clk;

    // Controller stand-in: logs each request and acks after ack_dly cycles.
    always @(negedge clk) begin
        if (init_n && rom_we && rom_req != prev_req) begin
            iss_q.push_back('{rom_addr, rom_din});
        end
        prev_req = rom_req;
        if (done) done_cnt++;
        if (ack_en && rom_req != rom_req_ack) begin
            if (ack_wait >= ack_dly) begin
                rom_req_ack = rom_req;
                ack_wait = 0;
            end else begin
                ack_wait++;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr_byte(input logic [23:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr = 1'b1;
        cyc(1);
        ioctl_wr = 1'b0;
    endtask

    function automatic logic [15:0] qsum();
        logic [15:0] s = 16'h0000;
        foreach (exp_q[i]) s = s + exp_q[i].d;
        return s;
    endfunction

    // Spec-level packing: bytes in order, one pending low byte at most.
    task automatic model();
        bit          pv = 1'b0;
        logic [7:0]  pb = '0;
        logic [22:0] pa = '0;
        logic [22:0] wa;
        exp_q.delete();
        foreach (ba[i]) begin
            wa = ba[i][23:1];
            if (!ba[i][0]) begin
                if (pv) exp_q.push_back('{pa, {8'h00, pb}});
                pv = 1'b1;
                pb = bd[i];
                pa = wa;
            end else if (pv && pa == wa) begin
                exp_q.push_back('{wa, {bd[i], pb}});
                pv = 1'b0;
            end else begin
                exp_q.push_back('{wa, {bd[i], 8'h00}});
            end
        end
        if (pv) exp_q.push_back('{pa, {8'h00, pb}});
    endtask

    task automatic finish_dl(input string nm);
        int d0;
        d0 = done_cnt;
        ioctl_download = 1'b0;
        for (int t = 0; t < 300 && done_cnt == d0; t++) cyc(1);
        cyc(4);
        chk({nm, "_done"}, done_cnt - d0, 1);
        chk({nm, "_we"}, rom_we, 1'b0);
    endtask

    task automatic cmp_q(input string nm, input logic ovf);
        logic [15:0] cexp;
        chk({nm, "_nw"}, iss_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < iss_q.size(); i++) begin
            chk($sformatf("%s_a%0d", nm, i), iss_q[i].a, exp_q[i].a);
            chk($sformatf("%s_d%0d", nm, i), iss_q[i].d, exp_q[i].d);
        end
        chk({nm, "_ovf"}, overflow, ovf);
`ifdef SDRAM_ROM_LOADER_CHECKSUM_EN
        cexp = qsum();
`else
        cexp = 16'h0000;
`endif
        chk({nm, "_csum"}, checksum, cexp);
    endtask

    task automatic run_dl(input string nm);
        iss_q.delete();
        ioctl_download = 1'b1;
        cyc(2);
        foreach (ba[i]) begin
            for (int t = 0; t < 100 && ioctl_wait; t++) cyc(1);
            wr_byte(ba[i], bd[i]);
            cyc($urandom_range(0, 1));
        end
        finish_dl(nm);
        cmp_q(nm, 1'b0);
    endtask

    vec_t        tbl [7];
    logic        r0;
    int          n0;
    int          fc;
    logic [23:0] a;

    initial begin
        tbl[0] = '{2, '{0, 1, 0, 0}, '{8'h11, 8'h22, 0, 0},
                   1, '{0, 0, 0}, '{16'h2211, 0, 0}};
        tbl[1] = '{3, '{0, 1, 2, 0}, '{8'hAA, 8'hBB, 8'hCC, 0},
                   2, '{0, 1, 0}, '{16'hBBAA, 16'h00CC, 0}};
        tbl[2] = '{2, '{4, 8, 0, 0}, '{8'h55, 8'h66, 0, 0},
                   2, '{2, 4, 0}, '{16'h0055, 16'h0066, 0}};
        tbl[3] = '{1, '{3, 0, 0, 0}, '{8'h77, 0, 0, 0},
                   1, '{1, 0, 0}, '{16'h7700, 0, 0}};
        tbl[4] = '{2, '{6, 9, 0, 0}, '{8'h12, 8'h34, 0, 0},
                   2, '{4, 3, 0}, '{16'h3400, 16'h0012, 0}};
        tbl[5] = '{4, '{10, 11, 12, 13}, '{8'h01, 8'h02, 8'h03, 8'h04},
                   2, '{5, 6, 0}, '{16'h0201, 16'h0403, 0}};
        tbl[6] = '{4, '{0, 1, 2, 3}, '{8'hFF, 8'hFF, 8'h02, 8'h00},
                   2, '{0, 1, 0}, '{16'hFFFF, 16'h0002, 0}};

        cyc(3);
        chk("rst_wait", ioctl_wait, 1'b0);
        chk("rst_addr", rom_addr, 0);
        chk("rst_din", rom_din, 0);
        chk("rst_we", rom_we, 1'b0);
        chk("rst_req", rom_req, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_csum", checksum, 0);
        init_n = 1'b1;
        cyc(3);

        // Odd strobe to request toggle takes two cycles.
        ack_en = 1'b1;
        ack_dly = 2;
        ioctl_download = 1'b1;
        cyc(2);
        iss_q.delete();
        wr_byte(24'd0, 8'h11);
        r0 = rom_req;
        ioctl_addr = 24'd1;
        ioctl_dout = 8'h22;
        ioctl_wr = 1'b1;
        cyc(1);
        ioctl_wr = 1'b0;
        chk("lat_n1_req", rom_req, r0);
        cyc(1);
        chk("lat_n2_req", rom_req, !r0);
        chk("lat_addr", rom_addr, 0);
        chk("lat_din", rom_din, 16'h2211);
        chk("lat_we", rom_we, 1'b1);
        finish_dl("lat");
        chk("lat_nw", iss_q.size(), 1);

        foreach (tbl[v]) begin
            ba.delete();
            bd.delete();
            exp_q.delete();
            for (int i = 0; i < tbl[v].n; i++) begin
                ba.push_back(tbl[v].a[i]);
                bd.push_back(tbl[v].d[i]);
            end
            for (int i = 0; i < tbl[v].nw; i++) begin
                exp_q.push_back('{tbl[v].ea[i], tbl[v].ed[i]});
            end
            ack_dly = $urandom_range(0, 3);
            run_dl($sformatf("tbl%0d", v));
        end
`ifdef SDRAM_ROM_LOADER_CHECKSUM_EN
        chk("csum_wrap", checksum, 16'h0001);
`else
        chk("csum_off", checksum, 16'h0000);
`endif

        // Ack withheld while the downloader ignores ioctl_wait.
        ack_en = 1'b0;
        ioctl_download = 1'b1;
        cyc(2);
        iss_q.delete();
        exp_q.delete();
        for (int k = 1; k <= 10; k++) begin
            a = 24'(24'h100 + 2 * k);
            wr_byte(a, 8'(2 * k));
            wr_byte(a + 24'd1, 8'(2 * k + 1));
            fc = (k == 1) ? 1 : ((k - 1 > 4) ? 4 : k - 1);
            if (k <= 5) exp_q.push_back('{a[23:1], {8'(2 * k + 1), 8'(2 * k)}});
            chk($sformatf("ovf_wait%0d", k), ioctl_wait, fc >= 3);
            chk($sformatf("ovf_flag%0d", k), overflow, k >= 6);
        end
        ack_en = 1'b1;
        ack_dly = 1;
        finish_dl("ovf");
        cmp_q("ovf", 1'b1);

        // Reset with a request in flight and the ack parity at one.
        ack_dly = 0;
        ioctl_download = 1'b1;
        cyc(2);
        for (int k = 0; k < 3 && rom_req_ack !== 1'b1; k++) begin
            wr_byte(24'(24'h40 + 2 * k), 8'h10);
            wr_byte(24'(24'h41 + 2 * k), 8'h20);
            cyc(6);
        end
        ack_en = 1'b0;
        wr_byte(24'h50, 8'h31);
        wr_byte(24'h51, 8'h32);
        cyc(3);
        chk("rsx_ack", rom_req_ack, 1'b1);
        chk("rsx_inflight", rom_req, 1'b0);
        n0 = iss_q.size();
        init_n = 1'b0;
        cyc(1);
        chk("rsx_req", rom_req, 1'b0);
        chk("rsx_we", rom_we, 1'b0);
        chk("rsx_addr", rom_addr, 0);
        chk("rsx_din", rom_din, 0);
        chk("rsx_ovf", overflow, 1'b0);
        chk("rsx_csum", checksum, 0);
        init_n = 1'b1;
        cyc(2);
        chk("rsx_sync_req", rom_req, 1'b1);
        chk("rsx_no_spur", iss_q.size(), n0);
        ack_en = 1'b1;
        wr_byte(24'd4, 8'h5A);
        wr_byte(24'd5, 8'hA5);
        cyc(6);
        chk("rsx_nw", iss_q.size(), n0 + 1);
        if (iss_q.size() == n0 + 1) begin
            chk("rsx_waddr", iss_q[n0].a, 2);
            chk("rsx_wdin", iss_q[n0].d, 16'hA55A);
        end
        chk("rsx_req2", rom_req, 1'b0);
        finish_dl("rsx");

        for (int r = 0; r < 25; r++) begin
            ba.delete();
            bd.delete();
            a = 24'($urandom_range(0, 4000));
            for (int i = 0; i < $urandom_range(1, 10); i++) begin
                ba.push_back(a);
                bd.push_back(8'($urandom));
                a = a + 24'($urandom_range(1, 3));
            end
            model();
            ack_dly = $urandom_range(0, 4);
            run_dl($sformatf("rnd%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
